// File: rtl/bus_ack_ctrl_if.sv
// rtl/bus_ack_ctrl_if.sv - 68000 bus-termination signal bundle between CPU/decoder side and bus_ack_ctrl.
interface bus_ack_ctrl_if;
  logic       AS;
  logic       IACK;
  logic [2:0] IPL_ACK;
  logic       ROMEN;
  logic       RAMEN;
  logic       DUARTEN;
  logic       MFPEN;
  logic       MFP_DTACK;
  logic       DTACK;
  logic       BERR;
  logic       VPA;

  modport master (
    output AS, IACK, IPL_ACK, ROMEN, RAMEN, DUARTEN, MFPEN, MFP_DTACK,
    input  DTACK, BERR, VPA
  );

  modport slave (
    input  AS, IACK, IPL_ACK, ROMEN, RAMEN, DUARTEN, MFPEN, MFP_DTACK,
    output DTACK, BERR, VPA
  );
endinterface

// File: rtl/bus_ack_ctrl.sv
// rtl/bus_ack_ctrl.sv - 68000 cycle termination: wait states, MFP DTACK pass-through, autovector, bus-error watchdog.
module bus_ack_ctrl #(
  parameter int unsigned ROM_WS    = 2,
  parameter int unsigned RAM_WS    = 0,
  parameter int unsigned DUART_WS  = 3,
  parameter int unsigned TIMEOUT   = 64,
  parameter logic [2:0]  MFP_LEVEL = 3'd5
) (
  input  logic          CLK,
  input  logic          RST,
  bus_ack_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_EXT,
    S_ACK,
    S_AUTOVEC,
    S_BUSERR
  } state_t;

  localparam logic [7:0] ROM_CNT   = 8'(ROM_WS);
  localparam logic [7:0] RAM_CNT   = 8'(RAM_WS);
  localparam logic [7:0] DUART_CNT = 8'(DUART_WS);
  localparam logic [7:0] WD_LAST   = 8'(TIMEOUT - 1);

  state_t     r_state;
  logic [7:0] r_cnt;
  logic [7:0] r_wd;
  logic       r_as_q;
  logic       r_mfp_ok;
  logic       r_dtack;
  logic       r_berr;
  logic       r_vpa;

  logic w_start;
  logic w_ext_ack;
  logic w_wd_expired;
  logic w_iack_mfp;

  // A start needs a genuine high-to-low AS transition, so a cycle in flight at reset is skipped.
  assign w_start      = r_as_q & ~bus.AS;
  assign w_ext_ack    = r_mfp_ok & ~bus.MFP_DTACK;
  assign w_wd_expired = (r_wd == WD_LAST);
  assign w_iack_mfp   = (bus.IPL_ACK == MFP_LEVEL);

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state  <= S_IDLE;
      r_cnt    <= 8'd0;
      r_wd     <= 8'd0;
      r_as_q   <= 1'b0;
      r_mfp_ok <= 1'b0;
      r_dtack  <= 1'b1;
      r_berr   <= 1'b1;
      r_vpa    <= 1'b1;
    end else begin
      r_as_q <= bus.AS;
      case (r_state)
        S_IDLE: begin
          r_dtack <= 1'b1;
          r_berr  <= 1'b1;
          r_vpa   <= 1'b1;
          if (w_start) begin
            r_wd     <= 8'd0;
            r_mfp_ok <= 1'b0;
            if (!bus.IACK) begin
              r_mfp_ok <= w_iack_mfp;
              r_state  <= w_iack_mfp ? S_EXT : S_AUTOVEC;
            end else if (!bus.MFPEN) begin
              r_mfp_ok <= 1'b1;
              r_state  <= S_EXT;
            end else if (!bus.DUARTEN) begin
              r_cnt   <= DUART_CNT;
              r_state <= S_WAIT;
            end else if (!bus.ROMEN) begin
              r_cnt   <= ROM_CNT;
              r_state <= S_WAIT;
            end else if (!bus.RAMEN) begin
              r_cnt   <= RAM_CNT;
              r_state <= S_WAIT;
            end else begin
              r_state <= S_EXT;
            end
          end
        end

        // Ack is tested before the watchdog so it wins a same-edge race.
        S_WAIT: begin
          if (bus.AS) begin
            r_state <= S_IDLE;
          end else if (r_cnt == 8'd0) begin
            r_dtack <= 1'b0;
            r_state <= S_ACK;
          end else begin
            r_cnt <= r_cnt - 8'd1;
            if (w_wd_expired) begin
              r_berr  <= 1'b0;
              r_state <= S_BUSERR;
            end else begin
              r_wd <= r_wd + 8'd1;
            end
          end
        end

        S_EXT: begin
          if (bus.AS) begin
            r_state <= S_IDLE;
          end else if (w_ext_ack) begin
            r_dtack <= 1'b0;
            r_state <= S_ACK;
          end else if (w_wd_expired) begin
            r_berr  <= 1'b0;
            r_state <= S_BUSERR;
          end else begin
            r_wd <= r_wd + 8'd1;
          end
        end

        S_ACK: begin
          if (bus.AS) begin
            r_dtack <= 1'b1;
            r_state <= S_IDLE;
          end
        end

        // VPA drops one edge after the start edge, giving the CPU its N+1 timing.
        S_AUTOVEC: begin
          if (bus.AS) begin
            r_vpa   <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_vpa <= 1'b0;
          end
        end

        S_BUSERR: begin
          if (bus.AS) begin
            r_berr  <= 1'b1;
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_dtack <= 1'b1;
          r_berr  <= 1'b1;
          r_vpa   <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.DTACK = r_dtack;
  assign bus.BERR  = r_berr;
  assign bus.VPA   = r_vpa;

  a_one_term: assert property (@(posedge CLK) disable iff (!RST)
    $countones({~r_dtack, ~r_berr, ~r_vpa}) <= 1);

endmodule

// File: tb/tb_bus_ack_ctrl.sv
// tb/tb_bus_ack_ctrl.sv - directed bench for bus_ack_ctrl with an edge-counting termination model.
module tb_bus_ack_ctrl;
  localparam int unsigned ROM_WS    = 2;
  localparam int unsigned RAM_WS    = 0;
  localparam int unsigned DUART_WS  = 3;
  localparam int unsigned TIMEOUT   = 64;
  localparam logic [2:0]  MFP_LEVEL = 3'd5;

  localparam int K_INT  = 0;
  localparam int K_MFP  = 1;
  localparam int K_AUTO = 2;
  localparam int K_NONE = 3;

  localparam int O_NONE  = 0;
  localparam int O_DTACK = 1;
  localparam int O_BERR  = 2;
  localparam int O_VPA   = 3;

  logic CLK;
  logic RST;
  bus_ack_ctrl_if bus();

  int checks   = 0;
  int failures = 0;

  bus_ack_ctrl #(
    .ROM_WS(ROM_WS), .RAM_WS(RAM_WS), .DUART_WS(DUART_WS),
    .TIMEOUT(TIMEOUT), .MFP_LEVEL(MFP_LEVEL)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Model: counts edges since the start edge and decides termination from region rules.
  int   edge_idx = 0;
  int   m_start  = 0;
  int   m_ws     = 0;
  int   m_kind   = K_NONE;
  int   m_out    = O_NONE;
  bit   m_active = 0;
  bit   m_as_q   = 0;

  always @(posedge CLK) begin
    int k;
    edge_idx++;
    if (!RST) begin
      m_active = 0;
      m_out    = O_NONE;
      m_as_q   = 0;
    end else begin
      if (m_out != O_NONE) begin
        if (bus.AS) begin
          m_out    = O_NONE;
          m_active = 0;
        end
      end else if (m_active) begin
        k = edge_idx - m_start;
        if (bus.AS) m_active = 0;
        else if (m_kind == K_AUTO) m_out = O_VPA;
        else if (m_kind == K_INT && k == m_ws + 1) m_out = O_DTACK;
        else if (m_kind == K_MFP && !bus.MFP_DTACK) m_out = O_DTACK;
        else if (k == int'(TIMEOUT)) m_out = O_BERR;
      end else if (m_as_q && !bus.AS) begin
        m_active = 1;
        m_start  = edge_idx;
        m_ws     = 0;
        if (!bus.IACK) m_kind = (bus.IPL_ACK == MFP_LEVEL) ? K_MFP : K_AUTO;
        else if (!bus.MFPEN) m_kind = K_MFP;
        else if (!bus.DUARTEN) begin m_kind = K_INT; m_ws = DUART_WS; end
        else if (!bus.ROMEN) begin m_kind = K_INT; m_ws = ROM_WS; end
        else if (!bus.RAMEN) begin m_kind = K_INT; m_ws = RAM_WS; end
        else m_kind = K_NONE;
      end
      m_as_q = bus.AS;
    end
  end

  always @(posedge CLK) begin
    logic [2:0] exp_v;
    logic [2:0] got_v;
    #1;
    exp_v = {m_out != O_DTACK, m_out != O_BERR, m_out != O_VPA};
    got_v = {bus.DTACK, bus.BERR, bus.VPA};
    checks++;
    if (got_v !== exp_v) begin
      failures++;
      $display("FAIL model edge %0d: DTACK/BERR/VPA got=%b required=%b", edge_idx, got_v, exp_v);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  task automatic check_out(input string name, input logic [2:0] exp_v);
    logic [2:0] got_v;
    got_v = {bus.DTACK, bus.BERR, bus.VPA};
    checks++;
    if (got_v !== exp_v) begin
      failures++;
      $display("FAIL %s: DTACK/BERR/VPA got=%b required=%b", name, got_v, exp_v);
    end
  endtask

  task automatic bus_idle();
    bus.AS        = 1'b1;
    bus.IACK      = 1'b1;
    bus.IPL_ACK   = 3'd0;
    bus.ROMEN     = 1'b1;
    bus.RAMEN     = 1'b1;
    bus.DUARTEN   = 1'b1;
    bus.MFPEN     = 1'b1;
    bus.MFP_DTACK = 1'b1;
  endtask

  // Leaves the bench just after edge N.
  task automatic start_cycle(input logic rom, input logic ram, input logic duart,
                             input logic mfp, input logic iack, input logic [2:0] ipl);
    bus.ROMEN   = rom;
    bus.RAMEN   = ram;
    bus.DUARTEN = duart;
    bus.MFPEN   = mfp;
    bus.IACK    = iack;
    bus.IPL_ACK = ipl;
    bus.AS      = 1'b0;
    tick(1);
  endtask

  task automatic end_cycle(input string name);
    bus_idle();
    tick(1);
    check_out(name, 3'b111);
    tick(1);
  endtask

  initial begin
    RST = 1'b0;
    bus_idle();
    bus.AS    = 1'b0;
    bus.RAMEN = 1'b0;
    tick(3);
    check_out("reset_state", 3'b111);
    RST = 1'b1;
    tick(5);
    check_out("as_low_through_reset", 3'b111);
    bus.AS = 1'b1;
    tick(1);
    start_cycle(1, 0, 1, 1, 1, 3'd0);
    check_out("ram_n", 3'b111);
    tick(1);
    check_out("ram_n1", 3'b011);
    end_cycle("ram_release");

    start_cycle(0, 1, 1, 1, 1, 3'd0);
    tick(2);
    check_out("rom_n2", 3'b111);
    tick(1);
    check_out("rom_n3", 3'b011);
    tick(2);
    check_out("rom_hold", 3'b011);
    end_cycle("rom_release");

    start_cycle(1, 1, 1, 0, 1, 3'd0);
    tick(4);
    check_out("mfp_n4", 3'b111);
    bus.MFP_DTACK = 1'b0;
    tick(1);
    check_out("mfp_n5", 3'b011);
    end_cycle("mfp_release");

    start_cycle(1, 1, 1, 0, 1, 3'd0);
    tick(63);
    check_out("mfp_to_n63", 3'b111);
    tick(1);
    check_out("mfp_to_n64", 3'b101);
    end_cycle("mfp_to_release");

    bus.MFP_DTACK = 1'b0;
    start_cycle(1, 1, 1, 1, 1, 3'd0);
    tick(63);
    check_out("unmapped_n63", 3'b111);
    tick(1);
    check_out("unmapped_n64", 3'b101);
    end_cycle("unmapped_release");

    start_cycle(1, 1, 1, 1, 0, 3'd5);
    tick(3);
    check_out("iack5_wait", 3'b111);
    bus.MFP_DTACK = 1'b0;
    tick(1);
    check_out("iack5_dtack", 3'b011);
    end_cycle("iack5_release");

    start_cycle(1, 1, 1, 1, 0, 3'd2);
    check_out("iack2_n", 3'b111);
    tick(1);
    check_out("iack2_n1", 3'b110);
    tick(3);
    check_out("iack2_hold", 3'b110);
    end_cycle("iack2_release");

    start_cycle(1, 1, 1, 0, 1, 3'd0);
    tick(63);
    bus.MFP_DTACK = 1'b0;
    tick(1);
    check_out("ack_beats_timeout", 3'b011);
    tick(1);
    check_out("ack_beats_timeout_hold", 3'b011);
    end_cycle("race_release");

    start_cycle(1, 1, 0, 1, 1, 3'd0);
    tick(2);
    bus_idle();
    tick(1);
    check_out("duart_abort", 3'b111);
    tick(5);
    check_out("duart_abort_later", 3'b111);

    start_cycle(1, 0, 1, 1, 1, 3'd0);
    tick(1);
    check_out("rst_ack_before", 3'b011);
    RST = 1'b0;
    tick(1);
    check_out("rst_in_ack", 3'b111);
    RST = 1'b1;
    tick(2);
    check_out("after_rst_as_low", 3'b111);
    end_cycle("after_rst_release");

    start_cycle(1, 0, 1, 1, 1, 3'd0);
    tick(1);
    check_out("ram_recover", 3'b011);
    end_cycle("ram_recover_release");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation ran past time limit");
    $fatal(1);
  end
endmodule

// File: doc/bus_ack_ctrl.md
# bus_ack_ctrl

Bus-cycle termination controller for the 68000 board. Sits directly downstream of the address decoder: it consumes the decoder's active-low chip selects plus the CPU strobes and produces the CPU-facing DTACK, BERR and VPA. It inserts per-region wait states, passes through the MFP's own DTACK, autovectors non-MFP interrupt acknowledges, and raises a bus error when no device terminates a cycle within a timeout.

## Interface

- ROM_WS, 2: wait states for ROM cycles (0..TIMEOUT-2)
- RAM_WS, 0: wait states for RAM cycles
- DUART_WS, 3: wait states for DUART cycles
- TIMEOUT, 64: watchdog limit in CLK edges (2..255)
- MFP_LEVEL, 3'd5: interrupt level answered by the MFP vector; all other levels are autovectored
- CLK  in  1  CPU clock; all inputs sampled on rising edge
- RST  in  1  reset, synchronous, active-low
- AS  in  1  CPU address strobe, active-low
- IACK  in  1  interrupt-acknowledge cycle (FC=111), active-low
- IPL_ACK  in  3  level being acknowledged (A3..A1), valid while IACK low
- ROMEN, RAMEN, DUARTEN, MFPEN  in  1 each  decoder chip selects, active-low
- MFP_DTACK  in  1  DTACK from MFP, active-low
- DTACK  out  1  to CPU, active-low, registered
- BERR  out  1  to CPU, active-low, registered
- VPA  out  1  to CPU, active-low, registered

## Operation

- States: IDLE, WAIT (internal wait-state count), EXT (waiting on MFP_DTACK), ACK, AUTOVEC, BUSERR.
- as_q holds the previous AS sample; reset value 0, so a cycle already in progress at reset is ignored until AS returns high.
- Start: in IDLE, AS sampled low with as_q high. Region latched at that edge, priority: IACK > MFPEN > DUARTEN > ROMEN > RAMEN > none.
  - IACK with IPL_ACK == MFP_LEVEL -> EXT.
  - IACK, other level -> AUTOVEC.
  - MFPEN -> EXT.
  - DUART/ROM/RAM -> WAIT, cnt loaded with that region's WS.
  - No select -> EXT with MFP_DTACK ignored, so the cycle can only end via timeout.
- WAIT: cnt == 0 -> ACK; else cnt decrements.
- EXT: MFP_DTACK low (only if the region is MFP or MFP IACK) -> ACK.
- Watchdog: wd cleared at start; increments each edge in WAIT/EXT. If wd == TIMEOUT-1 and no ack condition holds on that edge -> BUSERR.
- Exactly one output is low in ACK, AUTOVEC and BUSERR (DTACK, VPA or BERR respectively). That output is held until AS is sampled high; that edge returns to IDLE with all outputs high.
- AS sampled high in WAIT/EXT (aborted cycle) -> IDLE; no output asserted.
- Simultaneous ack condition and timeout on one edge: ack wins; BERR is not asserted.
- RST low: state IDLE, cnt=0, wd=0, as_q=0, DTACK=BERR=VPA=1. Applies on any edge, including mid-cycle.

## Timing

- N is the first edge with AS low (start edge).
- Internal region with W wait states: DTACK low after edge N+1+W. RAM_WS=0 gives DTACK low after N+1.
- MFP: DTACK low after the first edge N+k (k>=1) with MFP_DTACK sampled low.
- Autovector: VPA low after edge N+1.
- Timeout: BERR low after edge N+TIMEOUT.
- Release: outputs go high after the first edge with AS sampled high. That edge also updates as_q, so a new cycle can start at the next AS-low sample.

## Test plan

- Reset with AS held low, then RST high: no output asserts until AS goes high and low again. After that restart, a RAMEN cycle gives DTACK low after N+1.
- ROMEN cycle, ROM_WS=2: DTACK low after edge N+3. AS high at edge M: DTACK high after M, and BERR/VPA stay high throughout.
- MFPEN cycle, MFP_DTACK low at edge N+5: DTACK low after N+5. A second MFP cycle with MFP_DTACK never low: BERR low after N+64, and DTACK stays high.
- Unmapped cycle (all selects high): BERR low after N+TIMEOUT. Run once with MFP_DTACK held low: BERR still asserts.
- IACK with IPL_ACK=5: waits for MFP_DTACK, then DTACK asserts. IACK with IPL_ACK=2: VPA low after N+1, DTACK stays high.
- MFP_DTACK first sampled low at edge N+TIMEOUT: DTACK asserts and BERR stays high. AS deasserted mid-WAIT (DUART_WS=3): no output ever asserts. RST pulsed low during ACK: DTACK high on that edge.
